// File: rtl/rep_add_mult_ctrl.sv
// ============================================================================
// rep_add_mult_ctrl : repeated-addition multiplier, datapath and FSM in one block
// Optional build macro: MULT_OPERAND_SWAP_EN (iterate over the smaller operand)
// Revision: 1.0
// ============================================================================
`default_nettype none

module rep_add_mult_ctrl #(
  parameter int WIDTH  = 16,
  parameter int PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic [PWIDTH-1:0] prod,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [PWIDTH-1:0]  prod_q, prod_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   load_cnt;
  logic [WIDTH-1:0]   load_addend;
  logic [PWIDTH:0]    sum;

  generate
    if (WIDTH < 2 || PWIDTH < WIDTH || PWIDTH > 2 * WIDTH) begin : g_param_check
      $error("rep_add_mult_ctrl: illegal WIDTH/PWIDTH combination");
    end
  endgenerate

`ifdef MULT_OPERAND_SWAP_EN
  // Loop over the smaller operand so latency tracks min(a,b).
  always_comb begin
    load_cnt    = b_in;
    load_addend = a_in;
    if (a_in < b_in) begin
      load_cnt    = a_in;
      load_addend = b_in;
    end
  end
`else
  assign load_cnt    = b_in;
  assign load_addend = a_in;
`endif

  // One extra bit captures the carry out of the accumulator.
  assign sum = (PWIDTH+1)'(prod_q) + (PWIDTH+1)'(addend_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addend_d = addend_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          cnt_d    = load_cnt;
          addend_d = load_addend;
          prod_d   = '0;
          ovf_d    = 1'b0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          prod_d = sum[PWIDTH-1:0];
          cnt_d  = cnt_q - WIDTH'(1);
          if (sum[PWIDTH]) begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addend_q <= '0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addend_q <= addend_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign prod        = prod_q;
  assign ovf         = ovf_q;

endmodule

`default_nettype wire
